// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the multi-byte ALU sequencer:
//   - op codes (OP_ADD..OP_ROR), 9-bit ALU control words
//     {shift, right, A[2:0], B[1:0], C[1:0]}, and the sequencer states.
//   - Small decode helpers used by the sequencer top.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_INC = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_ASL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;

  // {shift, right, A[2:0], B[1:0], C[1:0]}
  localparam logic [8:0] ALUOP_ADD = 9'b00_000_01_10;
  localparam logic [8:0] ALUOP_SUB = 9'b00_000_11_10;
  localparam logic [8:0] ALUOP_INC = 9'b00_000_00_10;
  localparam logic [8:0] ALUOP_DEC = 9'b00_000_10_11;
  localparam logic [8:0] ALUOP_SHL = 9'b10_000_00_11;
  localparam logic [8:0] ALUOP_SHR = 9'b11_000_00_11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_ROR;
  endfunction

  // LSR/ROR walk the bytes MSB first so the carry register carries the
  // bit shifted out of the higher byte into the next lower one.
  function automatic logic op_right(input logic [3:0] op);
    return (op == OP_LSR) || (op == OP_ROR);
  endfunction

  function automatic logic [8:0] aluop_for(input logic [3:0] op);
    logic [8:0] ctl;
    case (op)
      OP_ADD:         ctl = ALUOP_ADD;
      OP_SUB, OP_CMP: ctl = ALUOP_SUB;
      OP_INC:         ctl = ALUOP_INC;
      OP_DEC:         ctl = ALUOP_DEC;
      OP_ASL, OP_ROL: ctl = ALUOP_SHL;
      OP_LSR, OP_ROR: ctl = ALUOP_SHR;
      default:        ctl = ALUOP_ADD;
    endcase
    return ctl;
  endfunction

  function automatic logic init_carry(input logic [3:0] op, input logic c_in);
    logic c;
    case (op)
      OP_ADD, OP_SUB, OP_ROL, OP_ROR: c = c_in;
      OP_CMP, OP_INC:                 c = 1'b1;
      default:                        c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu.sv
// alu
//   8-bit datapath slice shared by the sequencer.
//   alu_op = {shift, right, A[2:0], B[1:0], C[1:0]}
//     shift/right: 00 logic/arith, 10 shift left, 11 shift right, 01 pass DI
//     A: 000 add, 001 or, 010 and, 011 eor (others add)
//     B: 00 zero, 01 DR, 10 all-ones, 11 ~DR
//     C: 00 zero, 01 one, 1x carry input
// Ports:
//   alu_op  control word
//   r, dr   operand bytes
//   ci      carry in
//   di      bypass data
//   y       result byte
//   co      carry out (shift-out bit for shifts)
//   z       result is zero
//   v       signed overflow of the add path
module alu (
  input  logic [8:0] alu_op,
  input  logic [7:0] r,
  input  logic [7:0] dr,
  input  logic       ci,
  input  logic [7:0] di,
  output logic [7:0] y,
  output logic       co,
  output logic       z,
  output logic       v
);

  logic       shift;
  logic       right;
  logic [2:0] fn;
  logic [1:0] bsel;
  logic [1:0] csel;
  logic [7:0] bval;
  logic       cval;
  logic [8:0] sum;

  assign shift = alu_op[8];
  assign right = alu_op[7];
  assign fn    = alu_op[6:4];
  assign bsel  = alu_op[3:2];
  assign csel  = alu_op[1:0];

  always_comb begin
    case (bsel)
      2'b00:   bval = '0;
      2'b01:   bval = dr;
      2'b10:   bval = '1;
      default: bval = ~dr;
    endcase
    case (csel)
      2'b00:   cval = 1'b0;
      2'b01:   cval = 1'b1;
      default: cval = ci;
    endcase
  end

  assign sum = {1'b0, r} + {1'b0, bval} + {8'b0, cval};

  always_comb begin
    y  = sum[7:0];
    co = sum[8];
    v  = (r[7] == bval[7]) && (sum[7] != r[7]);
    if (shift && !right) begin
      y  = {r[6:0], cval};
      co = r[7];
      v  = 1'b0;
    end else if (shift && right) begin
      y  = {cval, r[7:1]};
      co = r[0];
      v  = 1'b0;
    end else if (right) begin
      y  = di;
      co = ci;
      v  = 1'b0;
    end else begin
      case (fn)
        3'b001: begin y = r | bval; co = ci; v = 1'b0; end
        3'b010: begin y = r & bval; co = ci; v = 1'b0; end
        3'b011: begin y = r ^ bval; co = ci; v = 1'b0; end
        default: ;
      endcase
    end
  end

  assign z = (y == 8'h00);

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Runs 8*BYTES-bit ADD/SUB/CMP/INC/DEC/ASL/LSR/ROL/ROR one byte per cycle
//   through a single 8-bit alu, chaining carry/shift-in through cr_q and
//   accumulating Z across slices.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start            request, sampled in IDLE or DONE
//   op, a, b, c_in   operation and operands, captured at accept
//   busy             high while bytes are being processed
//   done             one-cycle pulse when result/flags are updated
//   result, flag_*   final result and C/Z/N/V, held until the next run ends
module alu_seq #(
  parameter int unsigned BYTES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [8*BYTES-1:0] a,
  input  logic [8*BYTES-1:0] b,
  input  logic               c_in,
  output logic               busy,
  output logic               done,
  output logic [8*BYTES-1:0] result,
  output logic               flag_c,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_v
);

  import alu_seq_pkg::*;

  localparam int unsigned W  = 8 * BYTES;
  localparam int unsigned IW = $clog2(BYTES) + 1;

  state_e          state_q, state_d;
  logic [3:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    work_q;
  logic [W-1:0]    work_next;
  logic            cr_q;
  logic            z_acc_q;
  logic [IW-1:0]   idx_q;

  logic            accept;
  logic            last;
  logic            right;
  logic [7:0]      alu_y;
  logic            alu_co;
  logic            alu_z;
  logic            alu_v;

  assign right  = op_right(op_q);
  assign last   = right ? (idx_q == '0) : (idx_q == IW'(BYTES - 1));
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  alu u_alu (
    .alu_op (aluop_for(op_q)),
    .r      (a_q[8*idx_q +: 8]),
    .dr     (b_q[8*idx_q +: 8]),
    .ci     (cr_q),
    .di     (8'h00),
    .y      (alu_y),
    .co     (alu_co),
    .z      (alu_z),
    .v      (alu_v)
  );

  always_comb begin
    work_next = work_q;
    work_next[8*idx_q +: 8] = alu_y;
  end

  // Final result/flags are taken from the last slice's combinational ALU
  // outputs so they land on the DONE entry edge without an extra cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      cr_q    <= 1'b0;
      z_acc_q <= 1'b0;
      idx_q   <= '0;
      result  <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
    end else if (accept) begin
      op_q    <= op;
      a_q     <= a;
      b_q     <= b;
      cr_q    <= init_carry(op, c_in);
      z_acc_q <= 1'b1;
      idx_q   <= op_right(op) ? IW'(BYTES - 1) : '0;
    end else if (state_q == ST_RUN) begin
      cr_q    <= alu_co;
      z_acc_q <= z_acc_q & alu_z;
      work_q  <= work_next;
      if (!last) begin
        idx_q <= right ? idx_q - 1'b1 : idx_q + 1'b1;
      end else begin
        if (op_legal(op_q)) begin
          result <= (op_q == OP_CMP) ? a_q : work_next;
          flag_c <= alu_co;
          flag_z <= z_acc_q & alu_z;
          flag_n <= work_next[W-1];
          flag_v <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_v : 1'b0;
        end else begin
          result <= a_q;
          flag_c <= 1'b0;
          flag_z <= 1'b0;
          flag_n <= 1'b0;
          flag_v <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int unsigned BYTES = 3;
  localparam int unsigned W     = 8 * BYTES;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         flag_c, flag_z, flag_n, flag_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.BYTES(BYTES)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_v (flag_v)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] flags_now();
    return W'({flag_c, flag_z, flag_n, flag_v});
  endfunction

  // Reference: whole-width arithmetic, flags packed as {C,Z,N,V}.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic ci,
                                output logic [W-1:0] res, output logic [3:0] fl);
    logic [W:0] s;
    logic c, z, n, v;
    v = 1'b0;
    case (o)
      4'd0: begin
        s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        res = s[W-1:0]; c = s[W];
        v = (x[W-1] == y[W-1]) && (res[W-1] != x[W-1]);
      end
      4'd1: begin
        s = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, ci};
        res = s[W-1:0]; c = s[W];
        v = (x[W-1] != y[W-1]) && (res[W-1] != x[W-1]);
      end
      4'd2: begin
        s = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
        res = x; c = s[W];
      end
      4'd3: begin s = {1'b0, x} + 1; res = s[W-1:0]; c = s[W]; end
      4'd4: begin res = x - 1; c = (x != '0); end
      4'd5: begin res = x << 1; c = x[W-1]; end
      4'd6: begin res = x >> 1; c = x[0]; end
      4'd7: begin res = {x[W-2:0], ci}; c = x[W-1]; end
      4'd8: begin res = {ci, x[W-1:1]}; c = x[0]; end
      default: begin res = x; c = 1'b0; end
    endcase
    if (o == 4'd2) begin
      z = (s[W-1:0] == '0);
      n = s[W-1];
    end else begin
      z = (res == '0);
      n = res[W-1];
    end
    if (o > 4'd8) begin z = 1'b0; n = 1'b0; end
    fl = {c, z, n, v};
  endfunction

  // Called #1 after an edge with the DUT ready; returns #1 after the edge
  // following the done cycle.
  task automatic run_check(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic ci);
    logic [W-1:0] exp_res, prev_res;
    logic [3:0]   exp_fl;
    int           n;
    model(o, x, y, ci, exp_res, exp_fl);
    prev_res = result;
    op = o; a = x; b = y; c_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      chk({tag, "_busy"}, W'(busy), W'(1));
      chk({tag, "_hold"}, result, prev_res);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, W'(n), W'(BYTES));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_flg"}, flags_now(), W'(exp_fl));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, W'({busy, done}), W'(0));
  endtask

  initial begin
    logic [W-1:0] x;
    logic [3:0]   o;
    int           n;
    int           seen;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_res", result, '0);
    chk("rst_flg", flags_now(), '0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_check("add_carry", 4'd0, 24'h00FFFF, 24'h000001, 1'b0);
    run_check("add_ovf",   4'd0, 24'h7FFFFF, 24'h000001, 1'b0);
    run_check("sub_neg",   4'd1, 24'h000000, 24'h000001, 1'b1);
    run_check("cmp_eq",    4'd2, 24'h123456, 24'h123456, 1'b0);
    run_check("cmp_lt",    4'd2, 24'h000001, 24'h000002, 1'b0);
    run_check("inc_wrap",  4'd3, 24'hFFFFFF, 24'h000000, 1'b0);
    run_check("dec_wrap",  4'd4, 24'h000000, 24'h000000, 1'b0);
    run_check("ror_cin",   4'd8, 24'h000001, 24'h000000, 1'b1);
    run_check("lsr_one",   4'd6, 24'h000001, 24'h000000, 1'b0);
    run_check("rol_msb",   4'd7, 24'h800000, 24'h000000, 1'b0);
    run_check("asl_mix",   4'd5, 24'hC08001, 24'h000000, 1'b1);
    run_check("illegal",   4'd12, 24'hA5C381, 24'h0F0F0F, 1'b1);

    // start pulsed in RUN must neither change the run nor queue a new one
    op = 4'd0; a = 24'h000001; b = 24'h000002; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op = 4'd3; a = 24'h000777; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("ign_lat", W'(n), W'(BYTES));
    chk("ign_res", result, 24'h000003);
    @(posedge clk); #1;
    chk("ign_noq", W'({busy, done}), W'(0));

    // start held high through DONE: back-to-back runs
    op = 4'd3; a = 24'h000005; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 24'h000009;
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b_lat0", W'(n), W'(BYTES));
    chk("b2b_res0", result, 24'h000006);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", W'({busy, done}), W'(2));
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b_lat1", W'(n), W'(BYTES));
    chk("b2b_res1", result, 24'h00000A);
    @(posedge clk); #1;

    // reset asserted in the second RUN cycle
    op = 4'd0; a = 24'h111111; b = 24'h000001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mrst_busy", W'(busy), W'(0));
    chk("mrst_done", W'(done), W'(0));
    chk("mrst_res", result, '0);
    chk("mrst_flg", flags_now(), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < int'(BYTES) + 2; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("mrst_quiet", W'(seen), W'(0));
    run_check("post_rst", 4'd1, 24'h100000, 24'h000001, 1'b1);

    // randomized ops against the reference
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 9));
      if (o == 4'd9) o = 4'($urandom_range(9, 15));
      x = W'($urandom);
      case ($urandom_range(0, 5))
        0: x = '0;
        1: x = '1;
        default: ;
      endcase
      run_check("rand", o, x, W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
